// File: rtl/div_pkg.sv
// Shared constants for the divider / BCD display path: bus width, digit count,
// converter FSM encoding and the per-nibble shift/add-3 helpers.
package div_pkg;

  localparam int DIV_BUS_W  = 9;
  localparam int DIV_DIGITS = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Low three bits of the corrected nibble, shifted up, with a new LSB.
  function automatic logic [3:0] dabble_nib(input logic [3:0] nib, input logic lsb);
    logic [2:0] low;
    low = (nib >= 4'd5) ? 3'(nib + 4'd3) : nib[2:0];
    return {low, lsb};
  endfunction

  // Bit 3 of a corrected nibble: for any nibble in 0..9 this is simply nib >= 5.
  function automatic logic dabble_carry(input logic [3:0] nib);
    return (nib >= 4'd5);
  endfunction

endpackage

// File: rtl/div_bcd_converter_if.sv
// Bus between the sequential divider (master) and the BCD converter (slave).
interface div_bcd_converter_if
  import div_pkg::*;
#(
  parameter int W      = DIV_BUS_W,
  parameter int DIGITS = DIV_DIGITS
);

  logic                  div_ready;
  logic [W-1:0]          qbus;
  logic [W-1:0]          rbus;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  bcd_valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    output div_ready, qbus, rbus,
    input  q_bcd, r_bcd, bcd_valid, busy, overrun
  );

  modport slave (
    input  div_ready, qbus, rbus,
    output q_bcd, r_bcd, bcd_valid, busy, overrun
  );

endinterface

// File: rtl/dabble_step.sv
// One double-dabble iteration: add-3 correction on every nibble, then shift
// left by one with msb_i entering at bit 0. Purely combinational.
module dabble_step
  import div_pkg::*;
#(
  parameter int DIGITS = DIV_DIGITS
) (
  input  logic [4*DIGITS-1:0] acc_i,
  input  logic                msb_i,
  output logic [4*DIGITS-1:0] acc_o
);

  // The carry out of the top nibble is never needed, so it is not formed.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      if (gi == 0) begin : g_lsd
        assign acc_o[3:0] = dabble_nib(acc_i[3:0], msb_i);
      end else begin : g_upper
        assign acc_o[4*gi +: 4] = dabble_nib(acc_i[4*gi +: 4],
                                             dabble_carry(acc_i[4*(gi-1) +: 4]));
      end
    end
  endgenerate

endmodule

// File: rtl/div_bcd_converter.sv
// Captures divider quotient/remainder on a div_ready rising edge and converts
// both to packed BCD in parallel with a W-cycle double-dabble engine.
module div_bcd_converter
  import div_pkg::*;
#(
  parameter int W      = DIV_BUS_W,
  parameter int DIGITS = DIV_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  div_bcd_converter_if.slave  bus
);

  localparam int CNT_W = $clog2(W);
  localparam int BW    = 4 * DIGITS;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic [W-1:0]     q_sh_q, r_sh_q;
  logic [BW-1:0]    q_acc_q, r_acc_q;
  logic [BW-1:0]    q_step, r_step;
  logic [BW-1:0]    q_bcd_q, r_bcd_q;
  logic             valid_q, busy_q, overrun_q;
  logic             start_evt;

  assign start_evt = bus.div_ready & ~ready_q;

  dabble_step #(.DIGITS(DIGITS)) u_step_q (
    .acc_i (q_acc_q),
    .msb_i (q_sh_q[W-1]),
    .acc_o (q_step)
  );

  dabble_step #(.DIGITS(DIGITS)) u_step_r (
    .acc_i (r_acc_q),
    .msb_i (r_sh_q[W-1]),
    .acc_o (r_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d = ST_CONV;
          cnt_d   = '0;
        end
      end
      ST_CONV: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ready_q resets high so a divider already idle at reset release is not a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      q_sh_q    <= '0;
      r_sh_q    <= '0;
      q_acc_q   <= '0;
      r_acc_q   <= '0;
      q_bcd_q   <= '0;
      r_bcd_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= bus.div_ready;
      case (state_q)
        ST_IDLE: begin
          if (start_evt) begin
            q_sh_q  <= bus.qbus;
            r_sh_q  <= bus.rbus;
            q_acc_q <= '0;
            r_acc_q <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        ST_CONV: begin
          q_acc_q <= q_step;
          r_acc_q <= r_step;
          q_sh_q  <= {q_sh_q[W-2:0], 1'b0};
          r_sh_q  <= {r_sh_q[W-2:0], 1'b0};
          if (start_evt) overrun_q <= 1'b1;
        end
        ST_DONE: begin
          q_bcd_q <= q_acc_q;
          r_bcd_q <= r_acc_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          if (start_evt) overrun_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.q_bcd     = q_bcd_q;
  assign bus.r_bcd     = r_bcd_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_div_bcd_converter.sv
// Randomised and directed bench for div_bcd_converter, checked every cycle
// against a decimal-arithmetic model of the converter.
module tb_div_bcd_converter;
  import div_pkg::*;

  localparam int W      = DIV_BUS_W;
  localparam int DIGITS = DIV_DIGITS;
  localparam int BW     = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_bcd_converter_if #(.W(W), .DIGITS(DIGITS)) bus ();

  div_bcd_converter #(.W(W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a conversion is a pending job that completes W+1 edges after its start.
  logic          m_prev  = 1'b1;
  logic          m_busy  = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_ovr   = 1'b0;
  logic [BW-1:0] m_q     = '0;
  logic [BW-1:0] m_r     = '0;
  int            m_qv    = 0;
  int            m_rv    = 0;
  int            m_left  = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_prev = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
        m_q = '0; m_r = '0; m_left = 0;
      end else begin
        logic start;
        start  = bus.div_ready && !m_prev;
        m_prev = bus.div_ready;
        if (m_busy) begin
          if (start) m_ovr = 1'b1;
          m_left--;
          if (m_left == 0) begin
            m_busy  = 1'b0;
            m_valid = 1'b1;
            m_q     = to_bcd(m_qv);
            m_r     = to_bcd(m_rv);
          end
        end else if (start) begin
          m_busy  = 1'b1;
          m_valid = 1'b0;
          m_qv    = int'(bus.qbus);
          m_rv    = int'(bus.rbus);
          m_left  = W + 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_q_bcd",   32'(bus.q_bcd),     32'(m_q));
        check("cyc_r_bcd",   32'(bus.r_bcd),     32'(m_r));
        check("cyc_valid",   32'(bus.bcd_valid), 32'(m_valid));
        check("cyc_busy",    32'(bus.busy),      32'(m_busy));
        check("cyc_overrun", 32'(bus.overrun),   32'(m_ovr));
      end
    end
  end

  // Divider finishes: ready low for two cycles, then high with the new result.
  task automatic run(input int q, input int r, input logic [BW-1:0] eq, input logic [BW-1:0] er);
    @(negedge clk);
    bus.div_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.qbus = 9'(q);
    bus.rbus = 9'(r);
    bus.div_ready = 1'b1;
    @(negedge clk);
    check("start_busy",  32'(bus.busy),      32'd1);
    check("start_valid", 32'(bus.bcd_valid), 32'd0);
    repeat (W) @(negedge clk);
    check("last_busy",   32'(bus.busy),      32'd1);
    @(negedge clk);
    check("done_busy",   32'(bus.busy),      32'd0);
    check("done_valid",  32'(bus.bcd_valid), 32'd1);
    check("done_q_bcd",  32'(bus.q_bcd),     32'(eq));
    check("done_r_bcd",  32'(bus.r_bcd),     32'(er));
    $display("[TB] conv q=%0d r=%0d -> q_bcd=%03h r_bcd=%03h ovr=%0b",
             q, r, bus.q_bcd, bus.r_bcd, bus.overrun);
  endtask

  initial begin
    bus.div_ready = 1'b1;
    bus.qbus = '0;
    bus.rbus = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_q_bcd",   32'(bus.q_bcd),     32'd0);
    check("rst_r_bcd",   32'(bus.r_bcd),     32'd0);
    check("rst_valid",   32'(bus.bcd_valid), 32'd0);
    check("rst_busy",    32'(bus.busy),      32'd0);
    check("rst_overrun", 32'(bus.overrun),   32'd0);

    // Released with div_ready already high: no conversion may start.
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_busy",  32'(bus.busy),      32'd0);
    check("hold_valid", 32'(bus.bcd_valid), 32'd0);
    $display("[TB] ready held high 20 cycles, busy=%0b valid=%0b", bus.busy, bus.bcd_valid);

    run(32, 1, 12'h032, 12'h001);
    check("ovr_clear", 32'(bus.overrun), 32'd0);
    run(43, 0, 12'h043, 12'h000);
    run(511, 0, 12'h511, 12'h000);
    run(0, 255, 12'h000, 12'h255);
    check("model_pin", 32'(to_bcd(409)), 32'h409);

    for (int i = 0; i < 30; i++) begin
      int q, r;
      q = int'($urandom_range(0, (1 << W) - 1));
      r = int'($urandom_range(0, (1 << W) - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(q, r, to_bcd(q), to_bcd(r));
    end
    check("rand_ovr_clear", 32'(bus.overrun), 32'd0);

    // Second rising edge lands exactly on the DONE edge: ignored, flags overrun.
    @(negedge clk);
    bus.div_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.qbus = 9'd250; bus.rbus = 9'd17; bus.div_ready = 1'b1;
    repeat (9) @(negedge clk);
    bus.div_ready = 1'b0; bus.qbus = 9'd99;
    @(negedge clk);
    bus.div_ready = 1'b1;
    @(negedge clk);
    check("dedge_q_bcd",   32'(bus.q_bcd),     32'h250);
    check("dedge_r_bcd",   32'(bus.r_bcd),     32'h017);
    check("dedge_overrun", 32'(bus.overrun),   32'd1);
    @(negedge clk);
    check("dedge_no_retrig", 32'(bus.busy),    32'd0);
    $display("[TB] done-edge pulse: q_bcd=%03h ovr=%0b busy=%0b", bus.q_bcd, bus.overrun, bus.busy);

    // Second pulse four cycles into a conversion.
    bus.div_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.qbus = 9'd100; bus.rbus = 9'd5; bus.div_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.div_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.qbus = 9'd7; bus.div_ready = 1'b1;
    repeat (7) @(negedge clk);
    check("ovr_q_bcd",   32'(bus.q_bcd),   32'h100);
    check("ovr_r_bcd",   32'(bus.r_bcd),   32'h005);
    check("ovr_flag",    32'(bus.overrun), 32'd1);
    $display("[TB] overrun pulse: q_bcd=%03h ovr=%0b", bus.q_bcd, bus.overrun);
    run(12, 3, 12'h012, 12'h003);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Asynchronous reset five cycles into a conversion.
    @(negedge clk);
    bus.div_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.qbus = 9'd321; bus.rbus = 9'd45; bus.div_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_q_bcd",   32'(bus.q_bcd),     32'd0);
    check("arst_r_bcd",   32'(bus.r_bcd),     32'd0);
    check("arst_valid",   32'(bus.bcd_valid), 32'd0);
    check("arst_busy",    32'(bus.busy),      32'd0);
    check("arst_overrun", 32'(bus.overrun),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_valid", 32'(bus.bcd_valid), 32'd0);
    check("post_rst_busy",  32'(bus.busy),      32'd0);
    check("post_rst_q_bcd", 32'(bus.q_bcd),     32'd0);
    $display("[TB] reset mid-conversion: valid=%0b busy=%0b q_bcd=%03h",
             bus.bcd_valid, bus.busy, bus.q_bcd);

    run(99, 98, 12'h099, 12'h098);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_bcd_converter.md
Name: div_bcd_converter

Overview:
- Downstream consumer of the 9-bit sequential divider.
- Captures the divider's quotient and remainder when the divider signals completion.
- Converts both values to 3-digit packed BCD with a sequential double-dabble (shift/add-3) engine, running both conversions in parallel.
- Holds the BCD results for the seven-segment display driver.

Parameters:
- W, 9, operand width of quotient and remainder. Must equal the divider bus width.
- DIGITS, 3, number of BCD digits per result. Must satisfy 10^DIGITS > 2^W - 1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- div_ready  in  1  divider ready. Low while the divider is dividing; high when idle or done.
- qbus  in  W  divider quotient. Valid while div_ready is high.
- rbus  in  W  divider remainder. Valid while div_ready is high.
- q_bcd  out  4*DIGITS  packed BCD quotient. Most significant digit in the top nibble.
- r_bcd  out  4*DIGITS  packed BCD remainder, same packing as q_bcd.
- bcd_valid  out  1  high when q_bcd/r_bcd hold a completed conversion.
- busy  out  1  high while a conversion is in progress.
- overrun  out  1  sticky flag: a new div_ready rising edge arrived during a conversion.

Behaviour:
- Reset (rst low, asynchronous):
  - q_bcd = 0, r_bcd = 0, bcd_valid = 0, busy = 0, overrun = 0.
  - State goes to IDLE, bit counter = 0.
  - Registered ready_d is set to 1, so div_ready already high at reset release causes no conversion.
- Start event: the first clock edge at which div_ready = 1 and ready_d = 0. ready_d is div_ready registered every cycle.
- States: IDLE, CONV, DONE.
- IDLE:
  - On a start event, at that edge:
    - qbus/rbus go into the shift registers.
    - BCD accumulators clear; counter = 0.
    - busy = 1, bcd_valid = 0.
    - State goes to CONV.
  - Otherwise stay in IDLE and hold the outputs.
- CONV, each cycle, for each operand independently:
  - Every accumulator nibble >= 5 gets +3 (combinational).
  - {accumulator, shift register} then shifts left by 1.
  - counter increments. When counter reaches W-1, go to DONE on that edge.
  - Exactly W CONV cycles run.
- DONE, one cycle:
  - Accumulators copy to q_bcd/r_bcd; bcd_valid = 1, busy = 0.
  - State goes to IDLE.
- Latency:
  - Start event at edge t.
  - busy high from t through t+W+1; q_bcd/r_bcd/bcd_valid update at edge t+W+1 (t+10 for W = 9).
- bcd_valid is a level: it stays high until the next start event clears it.
- Start event in CONV or DONE:
  - Ignored; overrun = 1 (sticky until reset).
  - The current conversion completes with its originally captured operands.
- Start event in the same cycle DONE finishes: treated as occurring in DONE, so it is ignored and sets overrun.
- div_ready held high continuously: no retrigger; only rising edges count.
- Reset mid-CONV: conversion is aborted, all outputs return to reset values, and no partial result appears.
- Arithmetic:
  - Unsigned only. Accumulator is 4*DIGITS bits.
  - Add-3 is applied only to nibbles, with no carry between nibbles. Values above 2^W - 1 cannot occur.

Decomposition:
- Shared package div_pkg:
  - W and DIGITS defaults.
  - The state encoding constants IDLE/CONV/DONE.
  - The 9-bit bus width constant, shared with the divider and its bench.
- One sub-module, dabble_step (combinational):
  - Input: accumulator plus incoming MSB. Output: add-3-corrected, shifted accumulator.
  - Instantiated twice, once for quotient and once for remainder.

Test Plan:
- Divider computes 65/2, qbus = 32, rbus = 1, div_ready 0->1 -> at t+10: q_bcd = 0x032, r_bcd = 0x001, bcd_valid = 1, busy low, overrun = 0.
- Divider computes 129/3, qbus = 43, rbus = 0 -> q_bcd = 0x043, r_bcd = 0x000. bcd_valid drops at the start edge and returns high at t+10.
- Boundary values:
  - qbus = 511, rbus = 0 -> q_bcd = 0x511, r_bcd = 0x000.
  - qbus = 0, rbus = 255 -> q_bcd = 0x000, r_bcd = 0x255.
- Start event with qbus = 100, then a second ready pulse 4 cycles later with qbus = 7 -> q_bcd = 0x100, overrun = 1 and stays high until rst.
- Reset mid-conversion: rst low 5 cycles after a start event -> q_bcd = r_bcd = 0, bcd_valid = busy = 0 immediately (asynchronous). No result appears afterwards.
- Reset released with div_ready high, held high 20 cycles -> busy never asserts, bcd_valid stays 0.
